// File: rtl/jpeg_dec_pkg.sv
// jpeg_dec_pkg: shared widths, stuffing byte constants and the byte-filter action encoding for the JPEG bit unpacker.
package jpeg_dec_pkg;
  localparam int WORD_W = 32;
  localparam int BUF_W = 48;
  localparam int PEEK_W = 16;
  localparam logic [7:0] BYTE_FF = 8'hFF;
  localparam logic [7:0] BYTE_STUFF = 8'h00;
  typedef enum logic [1:0] {PUSH, PUSH_FF, DROP, MARKER} byte_act_t;
endpackage

// File: rtl/jpeg_bit_unpacker_if.sv
// jpeg_bit_unpacker_if: packed word stream in, peek/consume bit window and status out.
interface jpeg_bit_unpacker_if;
  import jpeg_dec_pkg::*;
  logic [WORD_W-1:0] word_in;
  logic word_en;
  logic word_last;
  logic word_rdy;
  logic [PEEK_W-1:0] peek_bits;
  logic [5:0] avail;
  logic consume_en;
  logic [4:0] consume_len;
  logic marker_det;
  logic [7:0] marker_code;
  logic frame_done;
  logic err;
  modport master (
    output word_in, word_en, word_last, consume_en, consume_len,
    input word_rdy, peek_bits, avail, marker_det, marker_code, frame_done, err
  );
  modport slave (
    input word_in, word_en, word_last, consume_en, consume_len,
    output word_rdy, peek_bits, avail, marker_det, marker_code, frame_done, err
  );
endinterface

// File: rtl/jpeg_bit_unpacker_unstuff.sv
// jpeg_unstuff: 0xFF/0x00 unstuffing and marker classification of one byte; JPEG_UNSTUFF_EN compiles the filter in, otherwise bytes pass raw.
module jpeg_unstuff
  import jpeg_dec_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic [7:0] byte_in,
  input  logic byte_go,
  input  logic frame_end,
  output byte_act_t act,
  output logic [7:0] push_byte,
  output logic mk
);
`ifdef JPEG_UNSTUFF_EN
  logic ff_seen;
  always_comb begin
    act = ff_seen ? (byte_in == BYTE_STUFF ? PUSH_FF : byte_in == BYTE_FF ? DROP : MARKER)
                  : (byte_in == BYTE_FF ? DROP : PUSH);
    push_byte = act == PUSH_FF ? BYTE_FF : byte_in;
    mk = act == MARKER;
  end
  // every 0xFF leaves the filter armed; anything else disarms it
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) ff_seen <= 1'b0;
    else if (frame_end) ff_seen <= 1'b0;
    else if (byte_go) ff_seen <= byte_in == BYTE_FF;
`else
  logic unused_in;
  assign unused_in = ^{clk, nrst, byte_go, frame_end};
  assign act = PUSH;
  assign push_byte = byte_in;
  assign mk = 1'b0;
`endif
endmodule

// File: rtl/jpeg_bit_unpacker.sv
// jpeg_bit_unpacker: 32-bit word to left-aligned bit window reader with optional unstuffing/marker detection (JPEG_UNSTUFF_EN).
module jpeg_bit_unpacker
  import jpeg_dec_pkg::*;
(
  input logic clk,
  input logic nrst,
  jpeg_bit_unpacker_if.slave bus
);
  logic [WORD_W-1:0] hold;
  logic hold_valid, hold_last;
  logic [1:0] bidx;
  logic [BUF_W-1:0] bits_q, bits_c, bits_n;
  logic [5:0] cnt, cnt_c, cnt_n;
  logic [7:0] cur_byte, push_byte, marker_code;
  byte_act_t act;
  logic mk, cons_ok, cons_bad, byte_go, push, accept, frame_end, err, frame_done, marker_det;
  jpeg_unstuff u_unstuff (
    .clk(clk), .nrst(nrst), .byte_in(cur_byte), .byte_go(byte_go),
    .frame_end(frame_end), .act(act), .push_byte(push_byte), .mk(mk)
  );
  // consume is applied before the push so a full buffer can drain and refill in one cycle
  always_comb begin
    cur_byte = hold[{~bidx, 3'b000} +: 8];
    cons_ok = bus.consume_en && ({1'b0, bus.consume_len} <= cnt);
    cons_bad = bus.consume_en && ({1'b0, bus.consume_len} > cnt);
    cnt_c = cons_ok ? cnt - {1'b0, bus.consume_len} : cnt;
    bits_c = cons_ok ? bits_q << bus.consume_len : bits_q;
    byte_go = hold_valid && (cnt_c <= 6'(BUF_W - 8));
    push = byte_go && (act == PUSH || act == PUSH_FF);
    bits_n = push ? bits_c | ({push_byte, {(BUF_W-8){1'b0}}} >> cnt_c) : bits_c;
    cnt_n = push ? cnt_c + 6'd8 : cnt_c;
    frame_end = byte_go && bidx == 2'd3 && hold_last;
    accept = bus.word_en && bus.word_rdy;
  end
  assign bus.word_rdy = !hold_valid || (bidx == 2'd3 && byte_go);
  assign bus.peek_bits = bits_q[BUF_W-1 -: PEEK_W];
  assign bus.avail = cnt;
  assign bus.marker_det = marker_det;
  assign bus.marker_code = marker_code;
  assign bus.frame_done = frame_done;
  assign bus.err = err;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      hold <= '0;
      hold_valid <= 1'b0;
      hold_last <= 1'b0;
      bidx <= 2'd0;
      bits_q <= '0;
      cnt <= 6'd0;
      err <= 1'b0;
      frame_done <= 1'b0;
      marker_det <= 1'b0;
      marker_code <= 8'h00;
    end else begin
      if (accept) begin
        hold <= bus.word_in;
        hold_valid <= 1'b1;
        hold_last <= bus.word_last;
        bidx <= 2'd0;
      end else if (byte_go) begin
        bidx <= bidx + 2'd1;
        hold_valid <= bidx != 2'd3;
      end
      bits_q <= bits_n;
      cnt <= cnt_n;
      err <= err | cons_bad;
      frame_done <= frame_end | (frame_done & !accept);
      marker_det <= byte_go & mk;
      if (byte_go && mk) marker_code <= cur_byte;
    end
endmodule

// File: tb/tb_jpeg_bit_unpacker.sv
// tb_jpeg_bit_unpacker: directed table and sequence checks; expectations follow JPEG_UNSTUFF_EN.
module tb_jpeg_bit_unpacker;
  logic clk, nrst;
  int pass_cnt = 0, tot_cnt = 0;
  jpeg_bit_unpacker_if bus();
  jpeg_bit_unpacker dut (.clk(clk), .nrst(nrst), .bus(bus));

  typedef struct {
    logic [31:0] w;
    logic [5:0] av;
    logic [15:0] pk;
    logic [7:0] mc;
  } vec_t;
  vec_t vt[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    cyc(1);
    nrst = 1'b1;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    int k;
    bus.word_in = w;
    bus.word_last = l;
    bus.word_en = 1'b1;
    for (k = 0; k < 100 && !bus.word_rdy; k++) cyc(1);
    if (!bus.word_rdy) chk("send_timeout", 48'd0, 48'd1);
    cyc(1);
    bus.word_en = 1'b0;
  endtask

  task automatic consume(input logic [4:0] l);
    bus.consume_en = 1'b1;
    bus.consume_len = l;
    cyc(1);
    bus.consume_en = 1'b0;
    bus.consume_len = 5'd0;
  endtask

  initial begin
`ifdef JPEG_UNSTUFF_EN
    vt[0] = '{32'h12345678, 6'd32, 16'h1234, 8'h00};
    vt[1] = '{32'hABFF00CD, 6'd24, 16'hABFF, 8'h00};
    vt[2] = '{32'hFFD91234, 6'd16, 16'h1234, 8'hD9};
    vt[3] = '{32'h00FF0000, 6'd24, 16'h00FF, 8'h00};
    vt[4] = '{32'hFFFF00AA, 6'd16, 16'hFFAA, 8'h00};
    vt[5] = '{32'h8001FF7E, 6'd16, 16'h8001, 8'h7E};
`else
    vt[0] = '{32'h12345678, 6'd32, 16'h1234, 8'h00};
    vt[1] = '{32'hABFF00CD, 6'd32, 16'hABFF, 8'h00};
    vt[2] = '{32'hFFD91234, 6'd32, 16'hFFD9, 8'h00};
    vt[3] = '{32'h00FF0000, 6'd32, 16'h00FF, 8'h00};
    vt[4] = '{32'hFFFF00AA, 6'd32, 16'hFFFF, 8'h00};
    vt[5] = '{32'h8001FF7E, 6'd32, 16'h8001, 8'h00};
`endif
    bus.word_in = '0;
    bus.word_en = 1'b0;
    bus.word_last = 1'b0;
    bus.consume_en = 1'b0;
    bus.consume_len = 5'd0;
    nrst = 1'b0;
    cyc(1);
    chk("rst_word_rdy", 48'(bus.word_rdy), 48'd1);
    chk("rst_peek", 48'(bus.peek_bits), 48'd0);
    chk("rst_avail", 48'(bus.avail), 48'd0);
    chk("rst_marker_det", 48'(bus.marker_det), 48'd0);
    chk("rst_marker_code", 48'(bus.marker_code), 48'd0);
    chk("rst_frame_done", 48'(bus.frame_done), 48'd0);
    chk("rst_err", 48'(bus.err), 48'd0);
    nrst = 1'b1;

    send(32'h12345678, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk($sformatf("lat_avail_%0d", i), 48'(bus.avail), 48'(8 * i));
      chk($sformatf("lat_done_%0d", i), 48'(bus.frame_done), 48'(i == 4));
    end
    chk("lat_peek", 48'(bus.peek_bits), 48'h1234);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      send(vt[i].w, 1'b1);
      cyc(5);
      chk($sformatf("tbl%0d_avail", i), 48'(bus.avail), 48'(vt[i].av));
      chk($sformatf("tbl%0d_peek", i), 48'(bus.peek_bits), 48'(vt[i].pk));
      chk($sformatf("tbl%0d_mcode", i), 48'(bus.marker_code), 48'(vt[i].mc));
      chk($sformatf("tbl%0d_done", i), 48'(bus.frame_done), 48'd1);
    end

    do_reset();
    send(32'hFFD91234, 1'b1);
    cyc(1);
    chk("mk_pulse_pre", 48'(bus.marker_det), 48'd0);
    cyc(1);
`ifdef JPEG_UNSTUFF_EN
    chk("mk_pulse", 48'(bus.marker_det), 48'd1);
`else
    chk("mk_pulse", 48'(bus.marker_det), 48'd0);
`endif
    cyc(1);
    chk("mk_pulse_post", 48'(bus.marker_det), 48'd0);

    do_reset();
    send(32'hABFF00CD, 1'b0);
    cyc(5);
    consume(5'd16);
`ifdef JPEG_UNSTUFF_EN
    chk("cons_peek", 48'(bus.peek_bits), 48'hCD00);
    chk("cons_avail", 48'(bus.avail), 48'd8);
`else
    chk("cons_peek", 48'(bus.peek_bits), 48'h00CD);
    chk("cons_avail", 48'(bus.avail), 48'd16);
`endif

    do_reset();
    send(32'h112233FF, 1'b0);
    send(32'h00445566, 1'b0);
    cyc(8);
    chk("full_avail", 48'(bus.avail), 48'd48);
    chk("full_rdy", 48'(bus.word_rdy), 48'd0);
    chk("full_peek", 48'(bus.peek_bits), 48'h1122);
    consume(5'd16);
    chk("drain_avail", 48'(bus.avail), 48'd40);
    chk("drain_peek", 48'(bus.peek_bits), 48'h33FF);

    do_reset();
    send(32'h123456FF, 1'b1);
    cyc(5);
    consume(5'd16);
    consume(5'd8);
    send(32'h00ABCDEF, 1'b1);
    cyc(5);
`ifdef JPEG_UNSTUFF_EN
    chk("fe_avail", 48'(bus.avail), 48'd32);
    chk("fe_peek", 48'(bus.peek_bits), 48'h00AB);
`else
    chk("fe_avail", 48'(bus.avail), 48'd40);
    chk("fe_peek", 48'(bus.peek_bits), 48'hFF00);
`endif
    chk("fe_done", 48'(bus.frame_done), 48'd1);

    do_reset();
    send(32'h12345678, 1'b0);
    cyc(5);
    consume(5'd16);
    chk("ill_avail16", 48'(bus.avail), 48'd16);
    chk("ill_peek16", 48'(bus.peek_bits), 48'h5678);
    consume(5'd8);
    chk("ill_avail8", 48'(bus.avail), 48'd8);
    chk("ill_err_pre", 48'(bus.err), 48'd0);
    consume(5'd12);
    chk("ill_avail", 48'(bus.avail), 48'd8);
    chk("ill_peek", 48'(bus.peek_bits), 48'h7800);
    chk("ill_err", 48'(bus.err), 48'd1);
    cyc(2);
    chk("ill_err_sticky", 48'(bus.err), 48'd1);

    send(32'hCAFEBABE, 1'b0);
    cyc(2);
    chk("mid_avail", 48'(bus.avail), 48'd24);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_avail", 48'(bus.avail), 48'd0);
    chk("mid_rst_peek", 48'(bus.peek_bits), 48'd0);
    chk("mid_rst_rdy", 48'(bus.word_rdy), 48'd1);
    chk("mid_rst_err", 48'(bus.err), 48'd0);
    chk("mid_rst_done", 48'(bus.frame_done), 48'd0);
    cyc(1);
    nrst = 1'b1;
    send(32'h12345678, 1'b1);
    cyc(1);
    chk("post_rst_avail", 48'(bus.avail), 48'd8);
    chk("post_rst_peek", 48'(bus.peek_bits), 48'h1200);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/jpeg_bit_unpacker.md
# jpeg_bit_unpacker

Decode-side front end of the JPEG entropy path. It is the reader for the 32-bit packed stream that the entropy packer emits. It accepts 32-bit words MSB-byte-first, removes 0xFF/0x00 byte stuffing, detects markers, and presents a left-aligned bit window to the downstream Huffman/VLC decoder through a peek/consume interface with backpressure.

## Interface
- `WORD_W`, 32, input word width; fixed at 32.
- `BUF_W`, 48, bit-buffer depth in bits.
- `clk`  in  1  rising-edge clock; the only clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `word_in`  in  32  packed stream word; byte [31:24] is first in the stream.
- `word_en`  in  1  `word_in` valid; accepted when `word_en && word_rdy`.
- `word_last`  in  1  qualifies the accepted word as the last word of the frame.
- `word_rdy`  out  1  block can accept a word this cycle.
- `peek_bits`  out  16  next 16 stream bits, MSB = oldest bit; bits beyond `avail` read 0.
- `avail`  out  6  valid bit count, 0..48.
- `consume_en`  in  1  drop `consume_len` bits this cycle.
- `consume_len`  in  5  bits to drop, 0..16; 0 is a no-op.
- `marker_det`  out  1  one-cycle pulse when a marker byte is decoded.
- `marker_code`  out  8  last marker byte; held until the next marker.
- `frame_done`  out  1  last byte of the `word_last` word has been processed.
- `err`  out  1  sticky; set by an illegal consume.

## Operation
- **Hold stage.** Register `hold` (32 bits) with `hold_valid` and byte index `bidx` (0..3). `word_rdy = !hold_valid || (bidx==3 && byte_go)`.
- **Byte processing.** One byte per cycle, `hold[31-8*bidx -: 8]`. `byte_go = hold_valid && (cnt_next_after_consume <= BUF_W-8)`.
- **Unstuff filter.** Flag `ff_seen` holds back each 0xFF byte:
  - byte 0xFF, `!ff_seen`: push nothing; set `ff_seen`.
  - `ff_seen`, byte 0x00: push 0xFF; clear `ff_seen`.
  - `ff_seen`, byte 0xFF: fill byte; push nothing; keep `ff_seen`.
  - `ff_seen`, any other byte: marker. Pulse `marker_det`, load `marker_code`, push nothing, clear `ff_seen`.
  - otherwise: push the byte.
  - `ff_seen` persists across word boundaries.
- **Bit buffer.** 48-bit left-aligned register with count `cnt` (`avail = cnt`).
  - Legal consume (`consume_len <= cnt`) in the same cycle as a push: shift left by `consume_len` first, then insert the byte at bit position `cnt - consume_len`.
  - Illegal consume (`consume_len > cnt`): ignored and `err` is set; a push in that cycle still occurs.
  - Vacated low bits are zero.
- **Frame end.** `frame_done` sets when the `bidx==3` byte of a `word_last` word is processed. It clears when the next word is accepted. `ff_seen` clears at frame end.
- **Reset.** Reset at any point, including mid-word or mid-frame: all state returns to reset values and any partial word is discarded.

## Timing
- Reset values:
  - `word_rdy` = 1
  - `peek_bits` = 0
  - `avail` = 0
  - `marker_det` = 0
  - `marker_code` = 0
  - `frame_done` = 0
  - `err` = 0
  - `hold_valid` = 0
  - `ff_seen` = 0
- Word accepted at edge N: byte 0 is processed at edge N+1, so `avail` reflects it after edge N+1. Bytes 1..3 follow at N+2..N+4 when not stalled.
- `word_rdy` allows back-to-back words with no bubble: sustained rate is 8 bits/cycle.
- Consume takes effect at the clock edge. `peek_bits` and `avail` are registered outputs.
- Buffer full: when `cnt > 40` after consume, byte processing stalls and `word_rdy` stays low if `hold_valid`.
- `marker_det` is asserted in the cycle following the edge at which the marker byte is processed.

## Configuration
- `JPEG_UNSTUFF_EN` defined: the unstuff filter and marker detection are compiled in, as described above.
- `JPEG_UNSTUFF_EN` undefined: every byte is pushed raw, `ff_seen` is absent, and `marker_det`/`marker_code` are tied to 0.

## Structure
- Package `jpeg_dec_pkg` holds:
  - `BUF_W`
  - `PEEK_W = 16`
  - `BYTE_FF = 8'hFF`
  - `BYTE_STUFF = 8'h00`
  - the byte-filter action encoding (PUSH, PUSH_FF, DROP, MARKER)
- One sub-module, `jpeg_unstuff`: the byte filter. It takes a byte and `ff_seen` and returns the action, the push byte and the marker flag. It owns the `ff_seen` register.

## Test plan
- Word 0x12345678, `word_last`=1, no consume → `avail` goes 8, 16, 24, 32 on successive cycles; `peek_bits`=0x1234; `frame_done`=1 after edge N+4.
- Word 0xABFF00CD → `avail`=24 and `peek_bits`=0xABFF. Then consume 16 → `peek_bits`=0xCD00 and `avail`=8.
- Words 0x112233FF then 0x00445566, no consume → stream is 11 22 33 FF 44 55 66. `avail` stops at 48 and `word_rdy` stays low. Consume 16 → 0x66 is pushed and `avail`=40.
- Word 0xFFD91234 → `marker_det` pulses once with `marker_code`=0xD9; `avail` ends at 16 with `peek_bits`=0x1234.
- `avail`=8, `consume_len`=12 → consume ignored, `avail` unchanged, `err`=1 and stays 1.
- Assert `nrst` low with `bidx`=2 → all outputs return to reset values immediately. After release, a new word starts at byte 0.
